// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that serialises JK-style hold/reset/set/toggle commands
// from NREQ requesters onto a shared WIDTH-bit flag bank.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [AW*NREQ-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [WIDTH-1:0]     q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [IW-1:0]     ptr_r, ptr_s;
  logic [IW-1:0]     idx_r, idx_s;
  logic [IW-1:0]     sel_s;
  logic [IW:0]       cand_s;
  logic              found_s;
  logic [1:0]        op_r, op_s;
  logic [AW-1:0]     addr_r, addr_s;
  logic [NREQ-1:0]   gnt_s, ack_s;
  logic              busy_s;
  logic [WIDTH-1:0]  q_s;

  function automatic logic jk_next(input logic [1:0] code, input logic cur);
    case (code)
      2'b00:   jk_next = cur;
      2'b01:   jk_next = 1'b0;
      2'b10:   jk_next = 1'b1;
      2'b11:   jk_next = ~cur;
      default: jk_next = cur;
    endcase
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin pick: first asserted request at or after the pointer, modulo NREQ
  always_comb begin
    sel_s   = ptr_r;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_r} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(NREQ)) begin
        cand_s = cand_s - (IW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        sel_s   = cand_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/APPLY sequencer
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    idx_s   = idx_r;
    op_s    = op_r;
    addr_s  = addr_r;
    gnt_s   = '0;
    ack_s   = '0;
    busy_s  = 1'b0;
    q_s     = q;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          idx_s   = sel_s;
          op_s    = op[2*sel_s +: 2];
          addr_s  = addr[AW*sel_s +: AW];
          gnt_s   = onehot(sel_s);
          busy_s  = 1'b1;
          state_s = APPLY;
        end else begin
          state_s = IDLE;
        end
      end
      APPLY: begin
        // An address past the top of the bank matches no bit, so q holds
        for (int b = 0; b < WIDTH; b++) begin
          if (addr_r == AW'(b)) begin
            q_s[b] = jk_next(op_r, q[b]);
          end else begin
            q_s[b] = q[b];
          end
        end
        ack_s = onehot(idx_r);
        if (idx_r == IW'(NREQ-1)) begin
          ptr_s = '0;
        end else begin
          ptr_s = idx_r + IW'(1);
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      idx_r   <= '0;
      op_r    <= 2'b00;
      addr_r  <= '0;
      gnt     <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      q       <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      idx_r   <= idx_s;
      op_r    <= op_s;
      addr_r  <= addr_s;
      gnt     <= gnt_s;
      ack     <= ack_s;
      busy    <= busy_s;
      q       <= q_s;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: table-driven single transactions,
// round-robin and reset-abort sequences, with a scoreboard of expected completions.
module tb_jk_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [11:0] addr;
  logic [3:0]  gnt, ack, gnt6, ack6;
  logic        busy, busy6;
  logic [7:0]  q;
  logic [5:0]  q6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         r;
    logic [7:0] q8;
    logic [5:0] q6;
    bit         chk6;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int         r;
    logic [1:0] o;
    logic [2:0] a;
    logic [7:0] exp_q;
    bit         scramble;
  } vec_t;
  vec_t vecs[5];

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr),
    .gnt(gnt), .ack(ack), .busy(busy), .q(q)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .AW(3)) dut6 (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr),
    .gnt(gnt6), .ack(ack6), .busy(busy6), .q(q6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] oh(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return one << r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int r, input logic [1:0] o, input logic [2:0] a);
    op[2*r +: 2]   = o;
    addr[3*r +: 3] = a;
  endtask

  task automatic push(input int r, input logic [7:0] q8, input logic [5:0] qq6, input bit c6);
    sb_t e;
    e.r = r; e.q8 = q8; e.q6 = qq6; e.chk6 = c6;
    sb.push_back(e);
  endtask

  // Called in the cycle the DUT should present its ack
  task automatic sb_check(input string name);
    sb_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: ack %0h seen with empty scoreboard", name, ack);
    end else begin
      e = sb.pop_front();
      chk({name, "_ack"}, 32'(ack), 32'(oh(e.r)));
      chk({name, "_q"}, 32'(q), 32'(e.q8));
      if (e.chk6) begin
        chk({name, "_ack6"}, 32'(ack6), 32'(oh(e.r)));
        chk({name, "_q6"}, 32'(q6), 32'(e.q6));
      end
    end
  endtask

  task automatic do_txn(input string name, input int r, input logic [1:0] o, input logic [2:0] a,
                        input logic [7:0] e8, input logic [5:0] e6, input bit c6, input bit scramble);
    set_cmd(r, o, a);
    req = oh(r);
    push(r, e8, e6, c6);
    @(posedge clk); #1;
    chk({name, "_gnt"}, 32'(gnt), 32'(oh(r)));
    chk({name, "_busy"}, 32'(busy), 32'd1);
    if (scramble) begin
      set_cmd(r, 2'b10, 3'd0);
      req = 4'b0000;
    end
    @(posedge clk); #1;
    sb_check(name);
    chk({name, "_gnt_off"}, 32'(gnt), 32'd0);
    req = 4'b0000;
    @(posedge clk); #1;
    chk({name, "_ack_clr"}, 32'(ack), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Structural invariants on both instances every cycle
  always @(negedge clk) begin
    checks++;
    if ((|gnt && |ack) || (busy !== |gnt) || (|gnt6 && |ack6) || (busy6 !== |gnt6)) begin
      errors++;
      $display("FAIL invariant: gnt=%0h ack=%0h busy=%0b gnt6=%0h ack6=%0h busy6=%0b",
               gnt, ack, busy, gnt6, ack6, busy6);
    end
  end

  initial begin
    logic [7:0] expq;
    vecs[0] = '{r: 1, o: 2'b11, a: 3'd5, exp_q: 8'h20, scramble: 1'b0};
    vecs[1] = '{r: 2, o: 2'b11, a: 3'd5, exp_q: 8'h00, scramble: 1'b0};
    vecs[2] = '{r: 3, o: 2'b10, a: 3'd5, exp_q: 8'h20, scramble: 1'b0};
    vecs[3] = '{r: 0, o: 2'b00, a: 3'd5, exp_q: 8'h20, scramble: 1'b1};
    vecs[4] = '{r: 1, o: 2'b01, a: 3'd5, exp_q: 8'h00, scramble: 1'b1};

    rst = 1'b1; req = 4'b0000; op = 8'h00; addr = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_gnt", 32'(gnt), 32'h0);

    do_txn("single_set", 0, 2'b10, 3'd3, 8'h08, 6'h00, 1'b0, 1'b0);
    pulse_reset();
    chk("q_after_reset", 32'(q), 32'h00);

    for (int i = 0; i < 5; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].o, vecs[i].a, vecs[i].exp_q,
             6'h00, 1'b0, vecs[i].scramble);
    end

    // All four requesting: grants must rotate 0,1,2,3 on alternate cycles
    pulse_reset();
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b10, 3'(i));
    req = 4'b1111;
    expq = 8'h00;
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("rr_gnt%0d", t), 32'(gnt), 32'(oh(t)));
      expq = expq | (8'h01 << t);
      push(t, expq, 6'h00, 1'b0);
      @(posedge clk); #1;
      sb_check($sformatf("rr%0d", t));
      req[t] = 1'b0;
      @(posedge clk); #1;
    end
    chk("rr_final_q", 32'(q), 32'h0F);
    chk("rr_final_gnt", 32'(gnt), 32'h0);

    // Out-of-range address on the 6-bit instance leaves its bank untouched
    pulse_reset();
    do_txn("oor_pre", 0, 2'b10, 3'd5, 8'h20, 6'h20, 1'b1, 1'b0);
    do_txn("oor", 0, 2'b10, 3'd7, 8'hA0, 6'h20, 1'b1, 1'b0);

    // Reset during APPLY: aborted, no ack, pointer back to 0
    pulse_reset();
    do_txn("pre_abort", 1, 2'b10, 3'd6, 8'h40, 6'h00, 1'b0, 1'b0);
    set_cmd(2, 2'b10, 3'd1);
    req = 4'b0100;
    @(posedge clk); #1;
    chk("abort_gnt", 32'(gnt), 32'(oh(2)));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ack", 32'(ack), 32'h0);
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_gnt_off", 32'(gnt), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b10, 3'(i));
    req = 4'b1111;
    @(posedge clk); #1;
    chk("post_abort_gnt", 32'(gnt), 32'(oh(0)));
    push(0, 8'h01, 6'h00, 1'b0);
    @(posedge clk); #1;
    sb_check("post_abort");
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("end_ack", 32'(ack), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
